// File: rtl/sprite_pkg.sv
// Shared types for the sprite scanline evaluator: OAM entry layout, slot record,
// default sizes and the scan FSM state encoding.
package sprite_pkg;

   localparam int OAM_DEPTH_DEFAULT   = 256;
   localparam int MAX_SPRITES_DEFAULT = 8;
   localparam int SPRITE_H_DEFAULT    = 16;

   typedef struct packed {
      logic       enable;
      logic [1:0] reserved;
      logic       flip_h;
      logic [2:0] palette;
      logic [5:0] sprite;
      logic [8:0] y;
      logic [9:0] x;
   } oam_entry_t;

   typedef struct packed {
      logic [9:0] x;
      logic [3:0] row;
      logic [5:0] sprite;
      logic [2:0] palette;
      logic       flip;
   } slot_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } scan_state_t;

endpackage

// File: rtl/sprite_scan_eval_if.sv
// OAM read port between the scanline evaluator (master) and the OAM memory (slave).
interface sprite_scan_eval_if #(
   parameter int ADDR_W = 8
);
   logic              oam_rd_en;
   logic [ADDR_W-1:0] oam_rd_addr;
   logic [31:0]       oam_rd_data;

   modport master (output oam_rd_en, output oam_rd_addr, input oam_rd_data);
   modport slave  (input oam_rd_en, input oam_rd_addr, output oam_rd_data);
endinterface

// File: rtl/oam_hit_check.sv
// Combinational test of one OAM entry against a scanline: hit flag and row inside the sprite.
module oam_hit_check
   import sprite_pkg::*;
#(
   parameter int SPRITE_H = SPRITE_H_DEFAULT
) (
   input  oam_entry_t entry,
   input  logic [8:0] line,
   output logic       hit,
   output logic [3:0] row
);

   logic [9:0] diff;
   logic       unused_fields;

   // One extra bit makes line < y show up as a set sign bit instead of wrapping into a hit.
   assign diff = {1'b0, line} - {1'b0, entry.y};
   assign hit  = entry.enable && !diff[9] && (diff < 10'(SPRITE_H));
   assign row  = diff[3:0];

   assign unused_fields = ^{entry.x, entry.sprite, entry.palette, entry.flip_h, entry.reserved};

endmodule

// File: rtl/sprite_scan_eval.sv
// Scans all OAM entries for one scanline and collects the first MAX_SPRITES hits,
// in OAM order, into a slot array read combinationally by the pixel fetcher.
module sprite_scan_eval
   import sprite_pkg::*;
#(
   parameter int OAM_DEPTH   = OAM_DEPTH_DEFAULT,
   parameter int MAX_SPRITES = MAX_SPRITES_DEFAULT,
   parameter int SPRITE_H    = SPRITE_H_DEFAULT,
   localparam int ADDR_W     = $clog2(OAM_DEPTH),
   localparam int CNT_W      = $clog2(MAX_SPRITES + 1),
   localparam int IDX_W      = $clog2(MAX_SPRITES)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [8:0]            line,
   output logic                  busy,
   output logic                  done,
   sprite_scan_eval_if.master    oam,
   output logic [CNT_W-1:0]      slot_count,
   output logic                  overflow,
   input  logic [IDX_W-1:0]      slot_idx,
   output logic [9:0]            slot_x,
   output logic [3:0]            slot_row,
   output logic [5:0]            slot_sprite,
   output logic [2:0]            slot_palette,
   output logic                  slot_flip
);

   scan_state_t       state, state_next;
   logic [8:0]        line_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rd_valid_q;
   slot_t             slots [MAX_SPRITES];
   oam_entry_t        rd_entry;
   logic              hit;
   logic [3:0]        hit_row;
   logic              eval_hit;
   logic              slots_full;
   slot_t             new_slot;
   slot_t             sel_slot;

   assign rd_entry   = oam.oam_rd_data;
   assign slots_full = (slot_count == CNT_W'(MAX_SPRITES));

   oam_hit_check #(.SPRITE_H(SPRITE_H)) u_hit_check (
      .entry (rd_entry),
      .line  (line_q),
      .hit   (hit),
      .row   (hit_row)
   );

   // Returned data is only meaningful one cycle after a read issued while scanning.
   assign eval_hit = rd_valid_q && hit && (state == ST_SCAN || state == ST_DRAIN);

   assign new_slot = '{x: rd_entry.x, row: hit_row, sprite: rd_entry.sprite,
                       palette: rd_entry.palette, flip: rd_entry.flip_h};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_SCAN;
         ST_SCAN: begin
            if (eval_hit && slots_full)                 state_next = ST_DONE;
            else if (addr_q == ADDR_W'(OAM_DEPTH - 1))  state_next = ST_DRAIN;
         end
         ST_DRAIN: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   assign busy        = (state == ST_SCAN) || (state == ST_DRAIN);
   assign done        = (state == ST_DONE);
   assign oam.oam_rd_en   = (state == ST_SCAN);
   assign oam.oam_rd_addr = addr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_q     <= '0;
         addr_q     <= '0;
         rd_valid_q <= 1'b0;
         slot_count <= '0;
         overflow   <= 1'b0;
         for (int i = 0; i < MAX_SPRITES; i++) slots[i] <= '0;
      end else begin
         rd_valid_q <= (state == ST_SCAN);
         addr_q     <= (state == ST_SCAN) ? addr_q + ADDR_W'(1) : '0;
         if (state == ST_IDLE && start) begin
            line_q     <= line;
            slot_count <= '0;
            overflow   <= 1'b0;
         end else if (eval_hit) begin
            if (slots_full) begin
               overflow <= 1'b1;
            end else begin
               slots[slot_count[IDX_W-1:0]] <= new_slot;
               slot_count <= slot_count + CNT_W'(1);
            end
         end
      end
   end

   // Slots beyond the valid count read as zero so stale entries never leak to the fetcher.
   always_comb begin
      sel_slot = '0;
      if (CNT_W'(slot_idx) < slot_count) sel_slot = slots[slot_idx];
   end

   assign slot_x       = sel_slot.x;
   assign slot_row     = sel_slot.row;
   assign slot_sprite  = sel_slot.sprite;
   assign slot_palette = sel_slot.palette;
   assign slot_flip    = sel_slot.flip;

endmodule

// File: tb/tb_sprite_scan_eval.sv
// Self-checking bench for sprite_scan_eval: table of row-boundary vectors, hand-written
// corner sequences and randomized OAM images checked against a list-based reference model.
module tb_sprite_scan_eval;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] line = '0;
   logic       busy, done, overflow;
   logic [3:0] slot_count;
   logic [2:0] slot_idx = '0;
   logic [9:0] slot_x;
   logic [3:0] slot_row;
   logic [5:0] slot_sprite;
   logic [2:0] slot_palette;
   logic       slot_flip;

   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   logic [31:0] oam_mem [256];

   int exp_slots[$];
   int exp_overflow, exp_latency, exp_rd_low;
   int got_latency, got_rd_low;

   sprite_scan_eval_if #(.ADDR_W(8)) oam_bus ();

   sprite_scan_eval dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .line         (line),
      .busy         (busy),
      .done         (done),
      .oam          (oam_bus),
      .slot_count   (slot_count),
      .overflow     (overflow),
      .slot_idx     (slot_idx),
      .slot_x       (slot_x),
      .slot_row     (slot_row),
      .slot_sprite  (slot_sprite),
      .slot_palette (slot_palette),
      .slot_flip    (slot_flip)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous OAM: data appears the cycle after the address.
   always @(posedge clk) if (oam_bus.oam_rd_en) oam_bus.oam_rd_data <= oam_mem[oam_bus.oam_rd_addr];

   typedef struct {
      logic [31:0] entry0;
      logic [8:0]  ln;
      int          exp_count;
      int          exp_row;
   } vec_t;

   function automatic logic [31:0] make_entry(input bit en, input int y, input int x,
                                              input int idx, input int pal, input bit flip);
      logic [31:0] e;
      e = {en, 2'b00, flip, 3'(pal), 6'(idx), 9'(y), 10'(x)};
      return e;
   endfunction

   task automatic clear_oam();
      for (int i = 0; i < 256; i++) oam_mem[i] = '0;
   endtask

   task automatic check_output(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Reference: walk OAM in order, list the hits, stop at the first one that finds no slot.
   task automatic compute_expected(input int ln);
      int y;
      exp_slots.delete();
      exp_overflow = 0;
      exp_latency  = 258;
      for (int i = 0; i < 256; i++) begin
         y = int'(oam_mem[i][18:10]);
         if (oam_mem[i][31] && ln >= y && ln - y < 16) begin
            if (exp_slots.size() == 8) begin
               exp_overflow = 1;
               exp_latency  = i + 3;
               break;
            end
            exp_slots.push_back(int'({oam_mem[i][9:0], 4'(ln - y), oam_mem[i][24:19],
                                      oam_mem[i][27:25], oam_mem[i][28]}));
         end
      end
      exp_rd_low = (exp_latency < 257) ? exp_latency : 257;
   endtask

   task automatic read_slot(input int i, output int word);
      slot_idx = 3'(i);
      #1;
      word = int'({slot_x, slot_row, slot_sprite, slot_palette, slot_flip});
   endtask

   // Pulses start with the given line; optionally re-pulses start extra_at cycles later.
   task automatic apply_stimulus(input logic [8:0] ln, input int extra_at);
      int t;
      @(negedge clk);
      start = 1'b1;
      line  = ln;
      t = cyc;
      got_latency = -1;
      got_rd_low  = -1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n < 400; n++) begin
         if (!oam_bus.oam_rd_en && got_rd_low < 0) got_rd_low = cyc - t;
         if (done) begin
            got_latency = cyc - t;
            break;
         end
         start = (extra_at != 0 && cyc - t == extra_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_scan(input string tag, input int ln);
      int word;
      compute_expected(ln);
      check_output({tag, " latency"}, got_latency, exp_latency);
      check_output({tag, " rd_en_low"}, got_rd_low, exp_rd_low);
      check_output({tag, " slot_count"}, int'(slot_count), exp_slots.size());
      check_output({tag, " overflow"}, int'(overflow), exp_overflow);
      for (int i = 0; i < 8; i++) begin
         read_slot(i, word);
         check_output($sformatf("%s slot%0d", tag, i), word,
                      (i < exp_slots.size()) ? exp_slots[i] : 0);
      end
   endtask

   initial begin
      vec_t vecs[$];
      int   word, t, near_pct;
      logic [8:0] ln;

      clear_oam();
      #1;
      check_output("reset busy", int'(busy), 0);
      check_output("reset done", int'(done), 0);
      check_output("reset rd_en", int'(oam_bus.oam_rd_en), 0);
      check_output("reset slot_count", int'(slot_count), 0);
      check_output("reset overflow", int'(overflow), 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // Row boundaries and filtering, single entry at OAM[0].
      vecs.push_back('{make_entry(1, 100, 5, 1, 1, 0),  9'd99,  0, 0});
      vecs.push_back('{make_entry(1, 100, 5, 1, 1, 0),  9'd100, 1, 0});
      vecs.push_back('{make_entry(1, 100, 5, 1, 1, 0),  9'd115, 1, 15});
      vecs.push_back('{make_entry(1, 100, 5, 1, 1, 0),  9'd116, 0, 0});
      vecs.push_back('{make_entry(0, 107, 5, 1, 1, 0),  9'd107, 0, 0});
      vecs.push_back('{make_entry(1, 470, 5, 1, 1, 0),  9'd5,   0, 0});
      vecs.push_back('{make_entry(1, 500, 9, 3, 4, 1),  9'd511, 1, 11});
      vecs.push_back('{make_entry(1, 0,   9, 3, 4, 1),  9'd0,   1, 0});
      foreach (vecs[v]) begin
         clear_oam();
         oam_mem[0] = vecs[v].entry0;
         apply_stimulus(vecs[v].ln, 0);
         check_output($sformatf("vec%0d latency", v), got_latency, 258);
         check_output($sformatf("vec%0d count", v), int'(slot_count), vecs[v].exp_count);
         if (vecs[v].exp_count > 0) begin
            read_slot(0, word);
            check_output($sformatf("vec%0d row", v), int'(slot_row), vecs[v].exp_row);
         end
      end

      // Single hit, with a second start at t+20 that must be ignored.
      clear_oam();
      oam_mem[5] = make_entry(1, 100, 320, 7, 2, 0);
      apply_stimulus(9'd107, 20);
      check_output("single latency", got_latency, 258);
      check_output("single count", int'(slot_count), 1);
      read_slot(0, word);
      check_output("single slot0", word, int'({10'd320, 4'd7, 6'd7, 3'd2, 1'b0}));
      check_scan("single", 107);

      // Overflow: ten hits, the ninth ends the scan early.
      clear_oam();
      for (int i = 0; i < 10; i++) oam_mem[i] = make_entry(1, 50, 10 * i, i, i % 8, i % 2);
      apply_stimulus(9'd55, 0);
      check_output("ovf latency", got_latency, 11);
      check_output("ovf rd_en_low", got_rd_low, 11);
      check_output("ovf overflow", int'(overflow), 1);
      read_slot(7, word);
      check_output("ovf slot7 x", int'(slot_x), 70);
      check_scan("ovf", 55);

      // Reset in the middle of a scan clears everything asynchronously.
      clear_oam();
      oam_mem[5] = make_entry(1, 100, 320, 7, 2, 0);
      @(negedge clk);
      start = 1'b1;
      line  = 9'd107;
      t = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc - t < 50) @(negedge clk);
      check_output("pre-reset busy", int'(busy), 1);
      check_output("pre-reset count", int'(slot_count), 1);
      #2 reset_n = 1'b0;
      #1;
      check_output("midreset busy", int'(busy), 0);
      check_output("midreset done", int'(done), 0);
      check_output("midreset rd_en", int'(oam_bus.oam_rd_en), 0);
      check_output("midreset count", int'(slot_count), 0);
      check_output("midreset overflow", int'(overflow), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      apply_stimulus(9'd107, 0);
      check_scan("post-reset", 107);

      // Randomized OAM images at varying hit densities, reserved bits scrambled.
      for (int r = 0; r < 6; r++) begin
         ln = 9'($urandom_range(0, 511));
         near_pct = (r == 0) ? 1 : (r == 1) ? 3 : (r == 2) ? 6 : $urandom_range(2, 60);
         for (int i = 0; i < 256; i++) begin
            oam_mem[i] = $urandom;
            if ($urandom_range(0, 99) < near_pct)
               oam_mem[i][18:10] = 9'(int'(ln) - int'($urandom_range(0, 20)));
         end
         apply_stimulus(ln, (r % 2 == 1) ? int'($urandom_range(2, 200)) : 0);
         check_scan($sformatf("rand%0d", r), int'(ln));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
